mips_bus_arbiter: RTL and testbench
===================================

MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- N_PORTS, default 2, number of client ports (2..8).
- DATA_WIDTH, default 32, data width; must be a multiple of 8.
- ADDR_WIDTH, default 32, address width.
- WAIT_LIMIT, default 0, maximum waitrequest cycles before abort; 0 disables the timeout.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_read  in  N_PORTS  per-port read request.
- req_write  in  N_PORTS  per-port write request.
- req_address  in  N_PORTS*ADDR_WIDTH  per-port address; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_writedata  in  N_PORTS*DATA_WIDTH  per-port write data.
- req_byteenable  in  N_PORTS*DATA_WIDTH/8  per-port byte enables.
- req_grant  out  N_PORTS  one-hot, one-cycle pulse when a port's request is issued.
- resp_valid  out  N_PORTS  one-hot, one-cycle pulse on transaction completion.
- resp_error  out  N_PORTS  one-hot, one-cycle pulse on timeout abort.
- resp_readdata  out  DATA_WIDTH  last read data returned.
- busy  out  1  high whenever the state is not IDLE.
- address  out  ADDR_WIDTH  Avalon master address.
- read  out  1  Avalon read.
- write  out  1  Avalon write.
- writedata  out  DATA_WIDTH  Avalon write data.
- byteenable  out  DATA_WIDTH/8  Avalon byte enables.
- waitrequest  in  1  Avalon slave stall.
- readdata  in  DATA_WIDTH  Avalon read data, valid in the cycle after an accepted read.

Function
REQ-003 The arbiter SHALL be a state machine with states IDLE, ISSUE and RDATA.
REQ-004 IDLE: if any request is high at the clock edge, the arbiter SHALL latch the winning port's address, writedata, byteenable and direction, and move to ISSUE; otherwise it SHALL stay in IDLE.
REQ-005 Arbitration SHALL be round-robin: the search starts at port ptr, then ptr+1 mod N_PORTS, and so on.
REQ-006 After each grant to port i, ptr SHALL become (i+1) mod N_PORTS.
REQ-007 If req_read and req_write are both high on one port, that port SHALL be treated as a write.
REQ-008 ISSUE: read or write SHALL be driven from the latched registers, and req_grant[i] SHALL be high only in the first ISSUE cycle.
REQ-009 The bus outputs SHALL stay stable while waitrequest is high.
REQ-010 ISSUE with waitrequest low at the edge: a write SHALL go to IDLE and pulse resp_valid[i] in the next cycle; a read SHALL go to RDATA.
REQ-011 RDATA: readdata SHALL be captured into resp_readdata at the edge, the state SHALL go to IDLE, and resp_valid[i] SHALL pulse in the next cycle.
REQ-012 resp_readdata SHALL hold its value until the next read completes and SHALL be unchanged by writes.
REQ-013 Timeout (WAIT_LIMIT>0): a counter SHALL clear on entry to ISSUE and increment on each ISSUE cycle with waitrequest high.
REQ-014 When that counter equals WAIT_LIMIT with waitrequest still high, read and write SHALL drop at the next edge, resp_error[i] SHALL pulse, the state SHALL return to IDLE, and resp_valid SHALL NOT pulse.
REQ-015 read and write SHALL be low in IDLE and RDATA, and SHALL never both be high.
REQ-016 A client SHALL deassert its request in its req_grant cycle; a request still high when the arbiter returns to IDLE SHALL be treated as a new transaction.
REQ-017 Minimum latency SHALL be: request sampled in cycle 0 -> bus issue in cycle 1 -> write resp_valid in cycle 2, or read resp_valid in cycle 3.
REQ-018 A new request SHALL be sampled in the same cycle that resp_valid pulses.

Reset
REQ-019 When reset is high at an edge, the following SHALL hold in the next cycle: state IDLE, ptr 0, timeout counter 0, read/write/req_grant/resp_valid/resp_error/busy all 0, resp_readdata 0.
REQ-020 A reset in ISSUE or RDATA SHALL abort the transaction with no response pulse, and read/write SHALL drop in the cycle after the reset edge.
REQ-021 A request present during reset SHALL NOT be granted until the first IDLE edge after reset is released.

Verification
REQ-022 Single read: port 0 reads 0x100, waitrequest 0, readdata 0xDEADBEEF -> read high in cycle 1; resp_valid[0] and resp_readdata=0xDEADBEEF in cycle 3.
REQ-023 Round-robin: ports 0 and 1 request continuously after each grant, starting from ptr=0 -> grant order 0,1,0,1.
REQ-024 Stall: write with waitrequest high for 4 cycles -> address, writedata and byteenable stable for 5 ISSUE cycles; resp_valid pulses the cycle after waitrequest falls.
REQ-025 Timeout: WAIT_LIMIT=3, waitrequest held high -> read drops after 4 ISSUE cycles; resp_error[i]=1, resp_valid=0.
REQ-026 Reset in RDATA -> no resp_valid; all outputs 0 in the next cycle; a pending port-1 request is granted after reset is released.
REQ-027 Both req_read and req_write high on port 2 (N_PORTS=4), byteenable 0b0011 -> write issued with byteenable 0b0011; read never asserted.

Source files
------------

// File: rtl/mips_bus_arbiter_if.sv
// mips_bus_arbiter_if: client request/response bundle plus the Avalon master bus of the arbiter.
//   master modport (arbiter view): in  req_read/req_write/req_address/req_writedata/req_byteenable,
//                                  in  waitrequest/readdata,
//                                  out req_grant/resp_valid/resp_error/resp_readdata/busy,
//                                  out address/read/write/writedata/byteenable.
//   slave modport: the same signals seen from the clients and the Avalon slave.
interface mips_bus_arbiter_if #(
    parameter int N_PORTS    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [N_PORTS-1:0]              req_read;
    logic [N_PORTS-1:0]              req_write;
    logic [N_PORTS*ADDR_WIDTH-1:0]   req_address;
    logic [N_PORTS*DATA_WIDTH-1:0]   req_writedata;
    logic [N_PORTS*DATA_WIDTH/8-1:0] req_byteenable;
    logic [N_PORTS-1:0]              req_grant;
    logic [N_PORTS-1:0]              resp_valid;
    logic [N_PORTS-1:0]              resp_error;
    logic [DATA_WIDTH-1:0]           resp_readdata;
    logic                            busy;
    logic [ADDR_WIDTH-1:0]           address;
    logic                            read;
    logic                            write;
    logic [DATA_WIDTH-1:0]           writedata;
    logic [DATA_WIDTH/8-1:0]         byteenable;
    logic                            waitrequest;
    logic [DATA_WIDTH-1:0]           readdata;

    modport master (
        input  req_read, req_write, req_address, req_writedata, req_byteenable, waitrequest, readdata,
        output req_grant, resp_valid, resp_error, resp_readdata, busy,
        output address, read, write, writedata, byteenable
    );

    modport slave (
        output req_read, req_write, req_address, req_writedata, req_byteenable, waitrequest, readdata,
        input  req_grant, resp_valid, resp_error, resp_readdata, busy,
        input  address, read, write, writedata, byteenable
    );
endinterface

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: round-robin arbiter granting N_PORTS clients one Avalon master bus.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : mips_bus_arbiter_if.master (client requests/responses and Avalon master signals)
module mips_bus_arbiter #(
    parameter int N_PORTS    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int WAIT_LIMIT = 0
) (
    input logic                clk,
    input logic                reset,
    mips_bus_arbiter_if.master bus
);
    localparam int PW = $clog2(N_PORTS);
    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = $clog2(WAIT_LIMIT + 2);

    typedef enum logic [1:0] {IDLE, ISSUE, RDATA} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d, port_q, port_d, win, idx;
    logic                  hit, timeout;
    logic                  wr_q, wr_d, first_q, first_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [BW-1:0]         be_q, be_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [N_PORTS-1:0]    valid_q, valid_d, error_q, error_d, req_any, sel;

    assign req_any = bus.req_read | bus.req_write;
    assign sel     = N_PORTS'(1) << port_q;
    assign timeout = WAIT_LIMIT > 0 && cnt_q == CW'(WAIT_LIMIT);

    // Offsets are walked from farthest to nearest so the port closest to ptr wins.
    always_comb begin
        win = ptr_q;
        hit = 1'b0;
        idx = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr_q) + k) % N_PORTS);
            if (req_any[idx]) begin
                win = idx;
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        port_d  = port_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        first_d = 1'b0;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        valid_d = '0;
        error_d = '0;
        case (state_q)
            IDLE: if (hit) begin
                state_d = ISSUE;
                ptr_d   = (int'(win) == N_PORTS - 1) ? '0 : win + 1'b1;
                port_d  = win;
                wr_d    = bus.req_write[win];
                addr_d  = bus.req_address[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_d = bus.req_writedata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                be_d    = bus.req_byteenable[int'(win)*BW +: BW];
                first_d = 1'b1;
                cnt_d   = '0;
            end
            ISSUE: begin
                if (!bus.waitrequest) begin
                    state_d = wr_q ? IDLE : RDATA;
                    valid_d = wr_q ? sel : '0;
                end else if (timeout) begin
                    state_d = IDLE;
                    error_d = sel;
                end else if (WAIT_LIMIT > 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RDATA: begin
                rdata_d = bus.readdata;
                state_d = IDLE;
                valid_d = sel;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            port_q  <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            first_q <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            valid_q <= '0;
            error_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            port_q  <= port_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    // Bus fields come straight from the latched request, so they cannot move during a stall.
    assign bus.req_grant     = first_q ? sel : '0;
    assign bus.resp_valid    = valid_q;
    assign bus.resp_error    = error_q;
    assign bus.resp_readdata = rdata_q;
    assign bus.busy          = state_q != IDLE;
    assign bus.address       = addr_q;
    assign bus.writedata     = wdata_q;
    assign bus.byteenable    = be_q;
    assign bus.read          = state_q == ISSUE && !wr_q;
    assign bus.write         = state_q == ISSUE && wr_q;
endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb_mips_bus_arbiter: scoreboard bench; a transaction-level model predicts grant order,
// bus contents, response kind, response cycle and readdata for each request round.
module tb_mips_bus_arbiter;
    localparam int N = 4, DW = 32, AW = 32, BW = 4, W = 3;

    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;

    mips_bus_arbiter_if #(.N_PORTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
    mips_bus_arbiter #(.N_PORTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_LIMIT(W)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        int port; bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [BW-1:0] be;
        int kind; logic [DW-1:0] rdata; int gcyc; int rcyc; int issue;
    } exp_t;
    typedef struct { int stall; logic [DW-1:0] rdata; } sl_t;
    typedef struct {
        bit on; bit rd; bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [BW-1:0] be;
        int stall; logic [DW-1:0] rdata;
    } rq_t;

    exp_t exp_q[$];
    sl_t  sl_q[$];
    rq_t  rq[N];
    sl_t  cur;
    int   cyc = 0, n_pass = 0, n_tot = 0, n_tmo = 0, ptr = 0, scnt = 0;
    logic [DW-1:0] mrd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Monitor: kind 0 = completes, 1 = times out, 2 = killed by reset.
    exp_t act;
    bit   have = 0, armed = 0;
    int   icnt = 0;
    always @(negedge clk) begin
        if (reset) begin
            if (armed) begin
                check("rst_read", bus.read, 0);
                check("rst_write", bus.write, 0);
                check("rst_grant", bus.req_grant, 0);
                check("rst_valid", bus.resp_valid, 0);
                check("rst_error", bus.resp_error, 0);
                check("rst_busy", bus.busy, 0);
                check("rst_readdata", bus.resp_readdata, 0);
            end
            armed = 1;
            have  = 0;
        end else begin
            armed = 0;
            if (bus.req_grant != 0) begin
                if (exp_q.size() == 0) check("unexp_grant", bus.req_grant, 0);
                else begin
                    act  = exp_q.pop_front();
                    have = 1;
                    icnt = 0;
                    check("grant_port", bus.req_grant, 64'(1) << act.port);
                    check("grant_cycle", cyc, act.gcyc);
                end
            end
            if (have && (bus.read || bus.write)) begin
                icnt++;
                check("dir_write", bus.write, act.wr);
                check("dir_read", bus.read, !act.wr);
                check("address", bus.address, act.addr);
                check("byteenable", bus.byteenable, act.be);
                if (act.wr) check("writedata", bus.writedata, act.wdata);
            end
            if (bus.resp_valid != 0 || bus.resp_error != 0) begin
                if (!have || act.kind == 2) check("unexp_resp", {bus.resp_valid, bus.resp_error}, 0);
                else begin
                    check("resp_valid", bus.resp_valid, act.kind == 0 ? 64'(1) << act.port : 0);
                    check("resp_error", bus.resp_error, act.kind == 1 ? 64'(1) << act.port : 0);
                    check("resp_cycle", cyc, act.rcyc);
                    check("issue_cycles", icnt, act.issue);
                    check("resp_readdata", bus.resp_readdata, act.rdata);
                    have = 0;
                end
            end
            check("busy", bus.busy, have);
            if (!have) check("bus_quiet", bus.read | bus.write, 0);
        end
    end

    // One cycle of client and slave behaviour, applied 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
        for (int i = 0; i < N; i++)
            if (bus.req_grant[i]) begin
                bus.req_read[i]  = 1'b0;
                bus.req_write[i] = 1'b0;
            end
        if (bus.req_grant != 0) begin
            if (sl_q.size() > 0) cur = sl_q.pop_front();
            else begin
                cur.stall = 0;
                cur.rdata = '0;
            end
            scnt = 0;
        end
        if (bus.read || bus.write) begin
            bus.waitrequest = scnt < cur.stall;
            scnt++;
        end else bus.waitrequest = 1'($urandom);
        bus.readdata = (bus.busy && !bus.read && !bus.write) ? cur.rdata : $urandom;
    endtask

    task automatic set_rq(input int p, input bit rd, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] be, input int st,
                          input logic [DW-1:0] r);
        rq[p] = '{1'b1, rd, wr, a, d, be, st, r};
    endtask

    task automatic clear_rq();
        for (int p = 0; p < N; p++) rq[p].on = 1'b0;
    endtask

    task automatic drive(input int p);
        bus.req_read[p]                    = rq[p].rd;
        bus.req_write[p]                   = rq[p].wr;
        bus.req_address[p*AW +: AW]        = rq[p].addr;
        bus.req_writedata[p*DW +: DW]      = rq[p].wdata;
        bus.req_byteenable[p*BW +: BW]     = rq[p].be;
    endtask

    // Predict a round where all active ports raise their request together, then play it out.
    task automatic run_round();
        bit   left[N];
        int   c, i;
        bit   rdc;
        exp_t e;
        c = cyc;
        for (int p = 0; p < N; p++) left[p] = rq[p].on;
        for (int g = 0; g < N; g++) begin
            i = -1;
            for (int k = N - 1; k >= 0; k--) if (left[(ptr + k) % N]) i = (ptr + k) % N;
            if (i >= 0) begin
                left[i]  = 1'b0;
                e.port   = i;
                e.wr     = rq[i].wr;
                e.addr   = rq[i].addr;
                e.wdata  = rq[i].wdata;
                e.be     = rq[i].be;
                e.kind   = rq[i].stall > W ? 1 : 0;
                e.issue  = e.kind == 1 ? W + 1 : rq[i].stall + 1;
                rdc      = !e.wr && e.kind == 0;
                if (rdc) mrd = rq[i].rdata;
                e.rdata  = mrd;
                e.gcyc   = c + 1;
                e.rcyc   = c + e.issue + int'(rdc) + 1;
                c        = e.rcyc;
                ptr      = (i + 1) % N;
                exp_q.push_back(e);
                sl_q.push_back('{rq[i].stall, rq[i].rdata});
            end
        end
        for (int p = 0; p < N; p++) if (rq[p].on) drive(p);
        while (cyc <= c) tick();
        if (exp_q.size() != 0 || have) begin
            $display("FAIL round_incomplete: %0d transactions still open, required 0", exp_q.size() + int'(have));
            n_tmo++;
            exp_q.delete();
        end
        bus.req_read  = '0;
        bus.req_write = '0;
    endtask

    initial begin
        int d;
        exp_t e;
        bus.req_read = '0; bus.req_write = '0; bus.req_address = '0;
        bus.req_writedata = '0; bus.req_byteenable = '0;
        bus.waitrequest = 1'b0; bus.readdata = '0;
        repeat (3) tick();
        reset = 1'b0;
        // Two rounds of ports 0 and 1 from ptr 0: grant order 0,1,0,1.
        repeat (2) begin
            clear_rq();
            set_rq(0, 1, 0, 32'h200, 32'h0, 4'hF, 0, $urandom);
            set_rq(1, 0, 1, 32'h300, $urandom, 4'hF, 0, 32'h0);
            run_round();
        end
        clear_rq(); set_rq(0, 1, 0, 32'h100, 32'h0, 4'hF, 0, 32'hDEADBEEF); run_round();
        clear_rq(); set_rq(1, 0, 1, 32'h140, 32'hCAFEF00D, 4'hA, W, 32'h0); run_round();
        clear_rq(); set_rq(3, 1, 0, 32'h180, 32'h0, 4'hF, W + 1, 32'h12345678); run_round();
        clear_rq(); set_rq(2, 1, 1, 32'h1C0, 32'h55AA55AA, 4'b0011, 1, 32'h0); run_round();
        // Reset while port 0 sits in the read-data phase; port 1 waits through the reset.
        clear_rq();
        set_rq(0, 1, 0, 32'h240, 32'h0, 4'hF, 0, 32'h0BADF00D);
        e = '{0, 1'b0, 32'h240, 32'h0, 4'hF, 2, 32'h0, cyc + 1, 0, 1};
        e.wdata = bus.req_writedata[DW-1:0];
        exp_q.push_back(e);
        sl_q.push_back('{0, 32'h0BADF00D});
        ptr = 1;
        drive(0);
        tick();
        tick();
        reset = 1'b1;
        clear_rq();
        set_rq(1, 0, 1, 32'h280, 32'h77778888, 4'hC, 0, 32'h0);
        drive(1);
        tick();
        tick();
        reset = 1'b0;
        ptr = 0;
        mrd = '0;
        run_round();
        for (int r = 0; r < 40; r++) begin
            for (int p = 0; p < N; p++) begin
                d = int'($urandom % 3);
                rq[p].on    = 1'($urandom);
                rq[p].rd    = d != 1;
                rq[p].wr    = d != 0;
                rq[p].addr  = $urandom;
                rq[p].wdata = $urandom;
                rq[p].be    = BW'($urandom);
                rq[p].stall = ($urandom % 4 == 0) ? W + 1 + int'($urandom % 3) : int'($urandom % (W + 1));
                rq[p].rdata = $urandom;
            end
            if (!(rq[0].on || rq[1].on || rq[2].on || rq[3].on)) rq[r % N].on = 1'b1;
            run_round();
        end
        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_tot + n_tmo);
        $finish;
    end
endmodule
